timer_cmp: RTL and testbench
============================

Name: timer_cmp

Overview:
Memory-mapped general-purpose timer: programmable prescaler, WIDTH-bit up-counter, compare register, three counting modes (free-run, periodic, one-shot), sticky match flag and level interrupt. Sits on the peripheral bus beside the other timers; the CPU accesses it through one 32-bit word-addressed register window. Mode 0 with PRESCALE = F_DIV reproduces the legacy free-running timer.

Parameters:
WIDTH, 32, counter and compare register width (1..32)
PRESCALE_W, 32, prescaler register width (1..32)
PRESCALE_RST, 100_000, reset value of PRESCALE; tick period = PRESCALE+1 clk cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
A  input  3  register word index
WD  input  32  write data
WE  input  1  write strobe, one write per cycle at A
RD  output  32  read data for register A, combinational
irq  output  1  interrupt request, level

Behaviour:
- Register map (A): 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE, 4 STATUS; A=5..7 read 0, writes ignored.
- CTRL: bit0 EN, bits[2:1] MODE (0 free-run, 1 periodic, 2 one-shot, 3 treated as 1), bit3 IE; other bits read 0.
- STATUS: bit0 MATCH, sticky; write 1 to bit0 clears, write 0 no effect.
- Reads zero-extend; writes take WD[WIDTH-1:0] / WD[PRESCALE_W-1:0].
- Reset (async, rst=1): CTRL=0, PRESCALE=PRESCALE_RST, COUNT=0, COMPARE=all ones, MATCH=0, internal prescale counter pcnt=0, irq=0. Reset mid-count aborts immediately.
- Prescaler: EN=0 -> pcnt held at 0, no ticks. EN=1 -> pcnt increments each cycle; when pcnt==PRESCALE, tick=1 for that cycle and pcnt<=0. PRESCALE=0 -> tick every cycle. A write to PRESCALE loads it and clears pcnt.
- Counter on tick: match = (COUNT==COMPARE).
  - No match: COUNT<=COUNT+1, wrapping from 2^WIDTH-1 to 0.
  - Match, MODE 0: COUNT<=COUNT+1 (wraps), MATCH<=1.
  - Match, MODE 1: COUNT<=0, MATCH<=1.
  - Match, MODE 2: COUNT<=0, MATCH<=1, EN<=0. pcnt clears in the following cycle because EN=0.
- MATCH sets in the cycle after the matching tick edge, i.e. registered, one cycle of latency.
- irq = MATCH & IE, combinational from registers. Clearing MATCH or IE drops irq next cycle.
- Simultaneous events:
  - Write COUNT in a tick cycle: written value loads; that tick neither increments nor matches.
  - Write STATUS clear in a match cycle: set wins, MATCH stays 1.
  - Write CTRL in a one-shot match cycle: written CTRL wins, including EN. COUNT still resets to 0 and MATCH sets.
  - Write COMPARE in a tick cycle: the match uses the old COMPARE.
- No other state. RD depends only on A and the current registers, never on WD or WE.

Test Plan:
- Reset: assert rst asynchronously mid-run -> RD(A=1)=100000, RD(A=2)=0, RD(A=3)=0xFFFFFFFF, irq=0 without a clk edge.
- Prescale: PRESCALE=3, CTRL=0x1 -> COUNT increments every 4 clk cycles; 40 cycles after enable, COUNT=10; EN=0 freezes COUNT.
- Periodic plus irq: PRESCALE=0, COMPARE=5, CTRL=0b1011 -> COUNT goes 0..5,0..5; MATCH and irq rise one cycle after the first tick with COUNT=5; writing STATUS=1 clears irq; irq reasserts on the next period.
- One-shot: PRESCALE=0, COMPARE=2, CTRL=0b0101 -> COUNT goes 0,1,2,0 then holds; CTRL reads 0b0100; MATCH=1; irq=0 because IE=0.
- Free-run wrap (WIDTH=8 instance): PRESCALE=0, COUNT=0xFE, COMPARE=0xFF, MODE 0 -> COUNT 0xFE,0xFF,0x00,0x01; MATCH set after the 0xFF tick.
- Collisions: write COUNT=0x40 on a tick cycle -> COUNT=0x40, no increment. STATUS clear coincident with match -> MATCH=1. Write to A=6 -> no register changes, reads 0.

Source files
------------

// File: rtl/timer_cmp_if.sv
// Register-window bus between the CPU side and the timer: word index, write data/strobe,
// combinational read data and the level interrupt.
interface timer_cmp_if;
  logic [2:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        irq;

  modport master (output A, WD, WE, input RD, irq);
  modport slave  (input A, WD, WE, output RD, irq);
endinterface

// File: rtl/timer_cmp.sv
// Prescaled up-counter with compare, free-run/periodic/one-shot modes, sticky MATCH and level irq.
// Writes land on the clock edge, reads are combinational, MATCH lags its tick by one cycle; never stalls.
module timer_cmp #(
  parameter int WIDTH        = 32,
  parameter int PRESCALE_W   = 32,
  parameter int PRESCALE_RST = 100_000
) (
  input logic        clk,
  input logic        rst,
  timer_cmp_if.slave bus
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_COUNT    = 3'd2;
  localparam logic [2:0] A_COMPARE  = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;

  localparam logic [1:0] MODE_FREE    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic [PRESCALE_W-1:0] PRESCALE_INIT = PRESCALE_W'(PRESCALE_RST);
  localparam logic [PRESCALE_W-1:0] PCNT_ONE      = PRESCALE_W'(1);
  localparam logic [WIDTH-1:0]      COUNT_ONE     = WIDTH'(1);

  logic                  en;
  logic [1:0]            mode;
  logic                  ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [WIDTH-1:0]      count;
  logic [WIDTH-1:0]      compare;
  logic                  match;

  logic wr_ctrl;
  logic wr_prescale;
  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic tick;
  logic hit;

  assign wr_ctrl     = bus.WE && (bus.A == A_CTRL);
  assign wr_prescale = bus.WE && (bus.A == A_PRESCALE);
  assign wr_count    = bus.WE && (bus.A == A_COUNT);
  assign wr_compare  = bus.WE && (bus.A == A_COMPARE);
  assign wr_status   = bus.WE && (bus.A == A_STATUS);

  assign tick = en && (pcnt == prescale);
  // A COUNT write in the tick cycle suppresses both the increment and the compare.
  assign hit  = tick && !wr_count && (count == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (wr_prescale || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= PRESCALE_INIT;
    end else if (wr_prescale) begin
      prescale <= bus.WD[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.WD[WIDTH-1:0];
    end else if (tick) begin
      // Mode 3 falls into the reload branch alongside periodic and one-shot.
      if (hit && (mode != MODE_FREE)) begin
        count <= '0;
      end else begin
        count <= count + COUNT_ONE;
      end
    end
  end

  // The compare uses the register value before any same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= '1;
    end else if (wr_compare) begin
      compare <= bus.WD[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= 1'b0;
      mode <= MODE_FREE;
      ie   <= 1'b0;
    end else if (wr_ctrl) begin
      en   <= bus.WD[0];
      mode <= bus.WD[2:1];
      ie   <= bus.WD[3];
    end else if (hit && (mode == MODE_ONESHOT)) begin
      en <= 1'b0;
    end
  end

  // A match set outranks a simultaneous software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (wr_status && bus.WD[0]) begin
      match <= 1'b0;
    end
  end

  always_comb begin
    bus.RD = '0;
    case (bus.A)
      A_CTRL:     bus.RD = {28'd0, ie, mode, en};
      A_PRESCALE: bus.RD = 32'(prescale);
      A_COUNT:    bus.RD = 32'(count);
      A_COMPARE:  bus.RD = 32'(compare);
      A_STATUS:   bus.RD = {31'd0, match};
      default:    bus.RD = '0;
    endcase
  end

  assign bus.irq = match & ie;

endmodule

// File: tb/tb_timer_cmp.sv
// Directed bench for timer_cmp: a 32-bit and an 8-bit instance, expectations queued by stimulus
// and checked by an independent monitor.
module tb_timer_cmp;

  logic clk;
  logic rst;

  timer_cmp_if bus32 ();
  timer_cmp_if bus8 ();

  timer_cmp dut32 (.clk(clk), .rst(rst), .bus(bus32));
  timer_cmp #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  localparam logic [2:0] R_CTRL = 3'd0, R_PRE = 3'd1, R_CNT = 3'd2, R_CMP = 3'd3, R_STAT = 3'd4;
  localparam int RD32 = 0, IRQ32 = 1, RD8 = 2, IRQ8 = 3;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          sel_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  event        chk_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of stimulus");
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expectation per presented sample and compares against the DUT output.
  initial begin
    forever begin
      int          s;
      logic [31:0] e;
      logic [31:0] act;
      string       nm;
      @(chk_ev);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: sample presented with empty expectation queue, got %0d entries, required 1", 0);
      end else begin
        s  = sel_q.pop_front();
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (s)
          RD32:    act = bus32.RD;
          IRQ32:   act = {31'd0, bus32.irq};
          RD8:     act = bus8.RD;
          default: act = {31'd0, bus8.irq};
        endcase
        n_cmp++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input logic [2:0] a, input logic [31:0] d);
    if (s < 2) begin
      bus32.A = a; bus32.WD = d; bus32.WE = 1'b1;
    end else begin
      bus8.A = a; bus8.WD = d; bus8.WE = 1'b1;
    end
    @(posedge clk);
    #1;
    bus32.WE = 1'b0;
    bus8.WE  = 1'b0;
  endtask

  task automatic chk(input int s, input logic [2:0] a, input logic [31:0] e, input string nm);
    if (s < 2) bus32.A = a;
    else       bus8.A  = a;
    #1;
    sel_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(nm);
    ->chk_ev;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus32.A = '0; bus32.WD = '0; bus32.WE = 1'b0;
    bus8.A  = '0; bus8.WD  = '0; bus8.WE  = 1'b0;
    step(3);
    rst = 1'b0;

    chk(RD32, R_CTRL, 32'd0, "rst_ctrl");
    chk(RD32, R_PRE, 32'd100000, "rst_prescale");
    chk(RD32, R_CNT, 32'd0, "rst_count");
    chk(RD32, R_CMP, 32'hFFFF_FFFF, "rst_compare");
    step(1);
    chk(RD32, R_STAT, 32'd0, "rst_status");
    chk(IRQ32, R_STAT, 32'd0, "rst_irq");
    chk(RD32, 3'd5, 32'd0, "rst_a5");
    step(1);

    // Prescaler: one tick per 4 cycles.
    wr(RD32, R_PRE, 32'd3);
    wr(RD32, R_CTRL, 32'h1);
    step(39);
    chk(RD32, R_CNT, 32'd9, "pre_count_39");
    step(1);
    chk(RD32, R_CNT, 32'd10, "pre_count_40");
    wr(RD32, R_CTRL, 32'h0);
    chk(RD32, R_CNT, 32'd10, "pre_disable");
    step(20);
    chk(RD32, R_CNT, 32'd10, "pre_frozen");

    // Periodic with irq, compare 5.
    wr(RD32, R_PRE, 32'd0);
    wr(RD32, R_CMP, 32'd5);
    wr(RD32, R_CNT, 32'd0);
    wr(RD32, R_STAT, 32'd1);
    wr(RD32, R_CTRL, 32'hB);
    chk(RD32, R_CNT, 32'd0, "per_count_e0");
    step(5);
    chk(RD32, R_CNT, 32'd5, "per_count_5");
    chk(RD32, R_STAT, 32'd0, "per_status_pre");
    chk(IRQ32, R_STAT, 32'd0, "per_irq_pre");
    step(1);
    chk(RD32, R_CNT, 32'd0, "per_reload");
    chk(RD32, R_STAT, 32'd1, "per_match");
    chk(IRQ32, R_STAT, 32'd1, "per_irq");
    wr(RD32, R_STAT, 32'd1);
    chk(IRQ32, R_STAT, 32'd0, "per_irq_cleared");
    chk(RD32, R_CNT, 32'd1, "per_count_after_clr");
    step(4);
    chk(RD32, R_CNT, 32'd5, "per2_count_5");
    chk(IRQ32, R_STAT, 32'd0, "per2_irq_pre");
    step(1);
    chk(IRQ32, R_STAT, 32'd1, "per2_irq");
    chk(RD32, R_CNT, 32'd0, "per2_reload");

    // Clear coincident with a match: the set wins.
    wr(RD32, R_STAT, 32'd1);
    chk(RD32, R_STAT, 32'd0, "col_clear");
    step(4);
    chk(RD32, R_CNT, 32'd5, "col_count_5");
    wr(RD32, R_STAT, 32'd1);
    chk(RD32, R_STAT, 32'd1, "col_set_wins");
    chk(RD32, R_CNT, 32'd0, "col_reload");

    // COUNT write on a tick: loaded value, no increment.
    wr(RD32, R_CNT, 32'h40);
    chk(RD32, R_CNT, 32'h40, "col_count_load");
    step(1);
    chk(RD32, R_CNT, 32'h41, "col_count_next");
    wr(RD32, R_CTRL, 32'h0);
    step(3);
    chk(RD32, R_CNT, 32'h42, "col_count_stop");

    // One-shot, compare 2, IE off.
    wr(RD32, R_STAT, 32'd1);
    wr(RD32, R_CMP, 32'd2);
    wr(RD32, R_CNT, 32'd0);
    wr(RD32, R_CTRL, 32'h5);
    step(2);
    chk(RD32, R_CNT, 32'd2, "os_count_2");
    chk(RD32, R_STAT, 32'd0, "os_status_pre");
    step(1);
    chk(RD32, R_CNT, 32'd0, "os_reload");
    chk(RD32, R_CTRL, 32'h4, "os_ctrl_en_clr");
    chk(RD32, R_STAT, 32'd1, "os_match");
    chk(IRQ32, R_STAT, 32'd0, "os_irq_masked");
    step(5);
    chk(RD32, R_CNT, 32'd0, "os_hold");

    // Unmapped write.
    wr(RD32, 3'd6, 32'hFFFF_FFFF);
    chk(RD32, 3'd6, 32'd0, "a6_read");
    chk(RD32, R_CTRL, 32'h4, "a6_ctrl");
    chk(RD32, R_PRE, 32'd0, "a6_prescale");
    chk(RD32, R_CMP, 32'd2, "a6_compare");
    step(1);
    chk(RD32, R_CNT, 32'd0, "a6_count");
    chk(RD32, R_STAT, 32'd1, "a6_status");

    // 8-bit free-run wrap.
    wr(RD8, R_CMP, 32'hABCD_EF12);
    chk(RD8, R_CMP, 32'h12, "w8_cmp_trunc");
    wr(RD8, R_PRE, 32'd0);
    wr(RD8, R_CMP, 32'hFF);
    wr(RD8, R_CNT, 32'hFE);
    wr(RD8, R_CTRL, 32'h1);
    chk(RD8, R_CNT, 32'hFE, "w8_fe");
    step(1);
    chk(RD8, R_CNT, 32'hFF, "w8_ff");
    chk(RD8, R_STAT, 32'd0, "w8_status_pre");
    step(1);
    chk(RD8, R_CNT, 32'h00, "w8_wrap");
    chk(RD8, R_STAT, 32'd1, "w8_match");
    step(1);
    chk(RD8, R_CNT, 32'h01, "w8_01");
    chk(IRQ8, R_STAT, 32'd0, "w8_irq_masked");

    // Async reset mid-run.
    wr(RD32, R_CTRL, 32'hB);
    chk(IRQ32, R_STAT, 32'd1, "mr_irq_before");
    step(2);
    rst = 1'b1;
    chk(IRQ32, R_STAT, 32'd0, "mr_irq");
    chk(RD32, R_PRE, 32'd100000, "mr_prescale");
    chk(RD32, R_CNT, 32'd0, "mr_count");
    chk(RD32, R_CMP, 32'hFFFF_FFFF, "mr_compare");
    chk(RD32, R_CTRL, 32'd0, "mr_ctrl");
    chk(RD8, R_CNT, 32'd0, "mr_count8");
    step(2);
    rst = 1'b0;
    step(2);

    if (exp_q.size() != 0) begin
      n_fail += exp_q.size();
      $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
